// File: rtl/axi_dma_r_pkg.sv
// Shared widths, fixed AR-channel attributes and FSM state type for the
// AXI read-side DMA engine.
package axi_dma_r_pkg;

  // System bus widths
  localparam int unsigned DDR_ADDR_W  = 32;
  localparam int unsigned MIG_BUS_W   = 64;

  // AXI field widths
  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_LOCK_W  = 1;
  localparam int unsigned AXI_CACHE_W = 4;
  localparam int unsigned AXI_PROT_W  = 3;
  localparam int unsigned AXI_QOS_W   = 4;
  localparam int unsigned AXI_RESP_W  = 2;

  // Fixed read-address attributes: full-width INCR bursts, normal access
  localparam logic [AXI_ID_W-1:0]    AR_ID    = '0;
  localparam logic [AXI_SIZE_W-1:0]  AR_SIZE  = AXI_SIZE_W'($clog2(MIG_BUS_W / 8));
  localparam logic [AXI_BURST_W-1:0] AR_BURST = 2'b01;
  localparam logic [AXI_LOCK_W-1:0]  AR_LOCK  = '0;
  localparam logic [AXI_CACHE_W-1:0] AR_CACHE = 4'd2;
  localparam logic [AXI_PROT_W-1:0]  AR_PROT  = 3'b010;
  localparam logic [AXI_QOS_W-1:0]   AR_QOS   = '0;

  // Read engine states
  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_ADDR_HS = 2'd1,
    R_DATA    = 2'd2
  } r_state_e;

endpackage

// File: rtl/axi_dma_r.sv
// AXI4 read-side DMA engine: accepts a single burst request on the databus
// side, issues one AR transaction and forwards every R beat back as a
// ready/rdata pulse, flagging response or burst-length errors.
module axi_dma_r
  import axi_dma_r_pkg::*;
#(
  parameter int unsigned USE_RAM = 1
) (
  input  logic                   clk,
  input  logic                   rst,

  // Databus side
  input  logic                   valid,
  input  logic [DDR_ADDR_W-1:0]  addr,
  input  logic [AXI_LEN_W-1:0]   len,
  output logic                   ready,
  output logic [MIG_BUS_W-1:0]   rdata,
  output logic                   error,

  // AXI read address channel
  output logic [AXI_ID_W-1:0]    m_axi_arid,
  output logic [DDR_ADDR_W-1:0]  m_axi_araddr,
  output logic [AXI_LEN_W-1:0]   m_axi_arlen,
  output logic [AXI_SIZE_W-1:0]  m_axi_arsize,
  output logic [AXI_BURST_W-1:0] m_axi_arburst,
  output logic [AXI_LOCK_W-1:0]  m_axi_arlock,
  output logic [AXI_CACHE_W-1:0] m_axi_arcache,
  output logic [AXI_PROT_W-1:0]  m_axi_arprot,
  output logic [AXI_QOS_W-1:0]   m_axi_arqos,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,

  // AXI read data channel
  input  logic [MIG_BUS_W-1:0]   m_axi_rdata,
  input  logic [AXI_RESP_W-1:0]  m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  r_state_e                state_q, state_d;
  logic [DDR_ADDR_W-1:0]   addr_q, addr_d;
  logic [AXI_LEN_W-1:0]    len_q, len_d;
  logic [AXI_LEN_W:0]      cnt_q, cnt_d;
  logic                    error_q, error_d;
  logic                    beat;
  logic [AXI_LEN_W:0]      len_ext;

  assign len_ext = {1'b0, len_q};

  // AR channel always presents the latched request, never the live inputs
  assign m_axi_arid    = AR_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AR_SIZE;
  assign m_axi_arburst = AR_BURST;
  assign m_axi_arlock  = AR_LOCK;
  assign m_axi_arcache = AR_CACHE;
  assign m_axi_arprot  = AR_PROT;
  assign m_axi_arqos   = AR_QOS;

  // Handshake strobes are pure decodes of the state register
  assign m_axi_arvalid = (state_q == R_ADDR_HS);
  assign m_axi_rready  = (state_q == R_DATA);
  assign beat          = m_axi_rvalid & m_axi_rready;
  assign error         = error_q;

  // Next-state, request latch, beat counter and sticky error computation
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    unique case (state_q)
      R_IDLE: begin
        if (valid) begin
          addr_d  = addr;
          len_d   = len;
          cnt_d   = '0;
          error_d = 1'b0;
          state_d = R_ADDR_HS;
        end
      end
      R_ADDR_HS: begin
        if (m_axi_arready) state_d = R_DATA;
      end
      R_DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (m_axi_rresp != '0) error_d = 1'b1;
          if (m_axi_rlast) begin
            // rlast ends the burst regardless; a short or long burst is flagged
            state_d = R_IDLE;
            if (cnt_q != len_ext) error_d = 1'b1;
          end else if (cnt_q == len_ext) begin
            // Expected final beat arrived without rlast: keep draining
            error_d = 1'b1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Engine state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= R_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  if (USE_RAM != 0) begin : g_comb_out
    // rdata is gated by the beat so it reads zero whenever no beat is delivered
    assign ready = beat;
    assign rdata = beat ? m_axi_rdata : '0;
  end else begin : g_reg_out
    logic                 ready_q, ready_d;
    logic [MIG_BUS_W-1:0] rdata_q, rdata_d;

    // Capture the beat one cycle late; data holds between beats
    always_comb begin
      ready_d = beat;
      rdata_d = rdata_q;
      if (beat) rdata_d = m_axi_rdata;
    end

    // Registered databus outputs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ready_q <= 1'b0;
        rdata_q <= '0;
      end else begin
        ready_q <= ready_d;
        rdata_q <= rdata_d;
      end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_axi_dma_r.sv
// Directed bench for axi_dma_r: drives both output variants (combinational
// and registered ready/rdata) from one shared stimulus and checks bursts
// from a vector table plus a mid-burst reset sequence.
module tb_axi_dma_r;
  import axi_dma_r_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  valid;
  logic [DDR_ADDR_W-1:0] addr;
  logic [AXI_LEN_W-1:0]  len;
  logic                  arready;
  logic [MIG_BUS_W-1:0]  rdat;
  logic [AXI_RESP_W-1:0] rresp;
  logic                  rlast;
  logic                  rvalid;

  // DUT a: USE_RAM=1, DUT b: USE_RAM=0
  logic                   ready_a, ready_b, error_a, error_b;
  logic [MIG_BUS_W-1:0]   rdata_a, rdata_b;
  logic [AXI_ID_W-1:0]    arid_a, arid_b;
  logic [DDR_ADDR_W-1:0]  araddr_a, araddr_b;
  logic [AXI_LEN_W-1:0]   arlen_a, arlen_b;
  logic [AXI_SIZE_W-1:0]  arsize_a, arsize_b;
  logic [AXI_BURST_W-1:0] arburst_a, arburst_b;
  logic [AXI_LOCK_W-1:0]  arlock_a, arlock_b;
  logic [AXI_CACHE_W-1:0] arcache_a, arcache_b;
  logic [AXI_PROT_W-1:0]  arprot_a, arprot_b;
  logic [AXI_QOS_W-1:0]   arqos_a, arqos_b;
  logic                   arvalid_a, arvalid_b, rready_a, rready_b;

  always #5 clk = ~clk;

  axi_dma_r #(.USE_RAM(1)) u_ram (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .len(len),
    .ready(ready_a), .rdata(rdata_a), .error(error_a),
    .m_axi_arid(arid_a), .m_axi_araddr(araddr_a), .m_axi_arlen(arlen_a),
    .m_axi_arsize(arsize_a), .m_axi_arburst(arburst_a), .m_axi_arlock(arlock_a),
    .m_axi_arcache(arcache_a), .m_axi_arprot(arprot_a), .m_axi_arqos(arqos_a),
    .m_axi_arvalid(arvalid_a), .m_axi_arready(arready),
    .m_axi_rdata(rdat), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready_a)
  );

  axi_dma_r #(.USE_RAM(0)) u_reg (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .len(len),
    .ready(ready_b), .rdata(rdata_b), .error(error_b),
    .m_axi_arid(arid_b), .m_axi_araddr(araddr_b), .m_axi_arlen(arlen_b),
    .m_axi_arsize(arsize_b), .m_axi_arburst(arburst_b), .m_axi_arlock(arlock_b),
    .m_axi_arcache(arcache_b), .m_axi_arprot(arprot_b), .m_axi_arqos(arqos_b),
    .m_axi_arvalid(arvalid_b), .m_axi_arready(arready),
    .m_axi_rdata(rdat), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready_b)
  );

  typedef struct {
    logic [DDR_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    int                    nbeats;    // beats the slave returns, rlast on the final one
    int                    err_beat;  // beat carrying rresp=10, 0 = none
    int                    ar_delay;
    bit                    gaps;      // random rvalid bubbles
    bit                    exp_error; // hand-computed final error flag
  } vec_t;

  int checks = 0;
  int passes = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  bit beat_prev = 1'b0;
  logic [MIG_BUS_W-1:0] data_prev = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Error flag expected after the first 'upto' beats of a vector
  function automatic bit exp_err(input vec_t v, input int upto);
    bit e = 1'b0;
    for (int j = 1; j <= upto; j++) begin
      if (j == v.err_beat) e = 1'b1;
      if (j == v.nbeats && (j - 1) != int'(v.len)) e = 1'b1;
      if (j != v.nbeats && (j - 1) == int'(v.len)) e = 1'b1;
    end
    return e;
  endfunction

  // Per-cycle ready/rdata check: comb variant same cycle, registered one later
  always @(negedge clk) begin
    if (rst) begin
      beat_prev = 1'b0;
    end else begin
      bit beat_now;
      beat_now = rvalid && rready_a;
      check("ready_comb", 64'(ready_a), 64'(beat_now));
      check("ready_reg_lag", 64'(ready_b), 64'(beat_prev));
      if (beat_now) check("rdata_comb", 64'(rdata_a), 64'(rdat));
      if (ready_b && beat_prev) check("rdata_reg", 64'(rdata_b), 64'(data_prev));
      if (ready_a) pulses_a++;
      if (ready_b) pulses_b++;
      beat_prev = beat_now;
      data_prev = rdat;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready_a"}, 64'(ready_a), 64'd0);
    check({tag, "_ready_b"}, 64'(ready_b), 64'd0);
    check({tag, "_rdata_a"}, 64'(rdata_a), 64'd0);
    check({tag, "_rdata_b"}, 64'(rdata_b), 64'd0);
    check({tag, "_error"}, 64'({error_a, error_b}), 64'd0);
    check({tag, "_arvalid"}, 64'({arvalid_a, arvalid_b}), 64'd0);
    check({tag, "_rready"}, 64'({rready_a, rready_b}), 64'd0);
    check({tag, "_araddr"}, 64'({araddr_a, araddr_b}), 64'd0);
    check({tag, "_arlen"}, 64'({arlen_a, arlen_b}), 64'd0);
  endtask

  // Issue the request and complete the AR handshake; ends at posedge+1 in R_DATA
  task automatic request_and_ar(input vec_t v);
    pulses_a = 0;
    pulses_b = 0;
    @(posedge clk); #1;
    valid = 1'b1; addr = v.addr; len = v.len;
    @(posedge clk); #1;
    valid = 1'b0; addr = $urandom; len = AXI_LEN_W'($urandom);
    @(negedge clk);
    check("err_cleared_on_accept", 64'({error_a, error_b}), 64'd0);
    check("arvalid_in_addr_hs", 64'({arvalid_a, arvalid_b}), 64'b11);
    check("rready_low_in_addr_hs", 64'({rready_a, rready_b}), 64'd0);
    for (int d = 0; d < v.ar_delay; d++) begin
      @(posedge clk); #1;
      valid = 1'($urandom_range(0, 1)); addr = $urandom; len = AXI_LEN_W'($urandom);
      @(negedge clk);
      check("arvalid_held", 64'({arvalid_a, arvalid_b}), 64'b11);
    end
    @(posedge clk); #1;
    arready = 1'b1; valid = 1'b0;
    @(negedge clk);
    check("araddr_a", 64'(araddr_a), 64'(v.addr));
    check("araddr_b", 64'(araddr_b), 64'(v.addr));
    check("arlen", 64'({arlen_a, arlen_b}), 64'({v.len, v.len}));
    @(posedge clk); #1;
    arready = 1'b0;
  endtask

  // Present one beat; error is checked against the beats already accepted
  task automatic send_beat(input vec_t v, input int vi, input int i);
    if (v.gaps) begin
      int n;
      n = $urandom_range(0, 2);
      repeat (n) begin
        rvalid = 1'b0; rdat = {$urandom, $urandom};
        @(negedge clk);
        check("rready_in_gap", 64'({rready_a, rready_b}), 64'b11);
        @(posedge clk); #1;
      end
    end
    rvalid = 1'b1;
    rdat   = {32'hA5A5_A5A5, 16'(vi), 16'(i)};
    rresp  = (i == v.err_beat) ? 2'b10 : 2'b00;
    rlast  = (i == v.nbeats);
    addr   = $urandom;
    @(negedge clk);
    check("rready_in_data", 64'({rready_a, rready_b}), 64'b11);
    check("err_progress", 64'({error_a, error_b}), {62'd0, {2{exp_err(v, i - 1)}}});
    @(posedge clk); #1;
  endtask

  task automatic run_burst(input vec_t v, input int vi);
    request_and_ar(v);
    for (int i = 1; i <= v.nbeats; i++) send_beat(v, vi, i);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    @(negedge clk);
    check("err_final_model", 64'({error_a, error_b}), {62'd0, {2{exp_err(v, v.nbeats)}}});
    check("err_final_table", 64'(error_a), 64'(v.exp_error));
    check("idle_arvalid", 64'({arvalid_a, arvalid_b}), 64'd0);
    check("idle_rready", 64'({rready_a, rready_b}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("pulses_comb", 64'(pulses_a), 64'(v.nbeats));
    check("pulses_reg", 64'(pulses_b), 64'(v.nbeats));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    vec_t vrst;
    vecs[0] = '{addr: 32'h100,  len: 8'd3, nbeats: 4, err_beat: 0, ar_delay: 2, gaps: 1'b0, exp_error: 1'b0};
    vecs[1] = '{addr: 32'h200,  len: 8'd0, nbeats: 1, err_beat: 0, ar_delay: 0, gaps: 1'b0, exp_error: 1'b0};
    vecs[2] = '{addr: 32'h340,  len: 8'd3, nbeats: 4, err_beat: 2, ar_delay: 1, gaps: 1'b0, exp_error: 1'b1};
    vecs[3] = '{addr: 32'h400,  len: 8'd3, nbeats: 2, err_beat: 0, ar_delay: 0, gaps: 1'b0, exp_error: 1'b1};
    vecs[4] = '{addr: 32'h480,  len: 8'd1, nbeats: 3, err_beat: 0, ar_delay: 0, gaps: 1'b0, exp_error: 1'b1};
    vecs[5] = '{addr: 32'h1000, len: 8'd5, nbeats: 6, err_beat: 0, ar_delay: 3, gaps: 1'b1, exp_error: 1'b0};
    vecs[6] = '{addr: 32'h2000, len: 8'd7, nbeats: 8, err_beat: 0, ar_delay: 1, gaps: 1'b1, exp_error: 1'b0};
    vrst    = '{addr: 32'h3000, len: 8'd7, nbeats: 8, err_beat: 0, ar_delay: 0, gaps: 1'b0, exp_error: 1'b0};

    rst = 1'b1; valid = 1'b0; addr = 32'hDEAD_BEEF; len = 8'd9;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    rdat = 64'hFFFF_0000_FFFF_0000;

    @(negedge clk);
    check_all_zero("reset");
    check("const_arid", 64'({arid_a, arid_b}), 64'd0);
    check("const_arsize", 64'({arsize_a, arsize_b}), 64'({3'd3, 3'd3}));
    check("const_arburst", 64'({arburst_a, arburst_b}), 64'b0101);
    check("const_arlock", 64'({arlock_a, arlock_b}), 64'd0);
    check("const_arcache", 64'({arcache_a, arcache_b}), 64'h22);
    check("const_arprot", 64'({arprot_a, arprot_b}), 64'({3'b010, 3'b010}));
    check("const_arqos", 64'({arqos_a, arqos_b}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; addr = '0; len = '0;
    @(negedge clk);
    check("idle_after_release", 64'({arvalid_a, rready_a}), 64'd0);

    for (int k = 0; k < 7; k++) run_burst(vecs[k], k);

    // Mid-burst reset after beat 2 of a len=7 burst, with beat 3 pending
    request_and_ar(vrst);
    send_beat(vrst, 9, 1);
    send_beat(vrst, 9, 2);
    rvalid = 1'b1; rdat = 64'h1234_5678_9ABC_DEF0; rlast = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rready", 64'({rready_a, rready_b}), 64'd0);
    check("post_rst_ready", 64'({ready_a, ready_b}), 64'd0);
    check("post_rst_arvalid", 64'({arvalid_a, arvalid_b}), 64'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    @(negedge clk);
    check("post_rst_ready_b_late", 64'(ready_b), 64'd0);
    run_burst(vecs[0], 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi_dma_r.md
AXI_DMA_R -- requirements
Module: axi_dma_r

Interface
REQ-001 Parameter: USE_RAM, 1, 1 = ready/rdata driven combinationally from the R channel; 0 = ready/rdata registered one cycle later.
REQ-002 One clock; reset is asynchronous and active-high: clk  input  1  system clock; rst  input  1  asynchronous active-high reset.
REQ-003 valid  input  1  databus read request.
REQ-004 addr  input  `DDR_ADDR_W  burst start byte address.
REQ-005 len  input  `AXI_LEN_W  beats minus one.
REQ-006 ready  output  1  one pulse per delivered beat.
REQ-007 rdata  output  `MIG_BUS_W  beat data.
REQ-008 error  output  1  sticky burst error flag.
REQ-009 m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos  output  `AXI_*_W widths  read address channel.
REQ-010 m_axi_arvalid  output  1; m_axi_arready  input  1.
REQ-011 m_axi_rdata  input  `MIG_BUS_W; m_axi_rresp  input  `AXI_RESP_W; m_axi_rlast  input  1; m_axi_rvalid  input  1; m_axi_rready  output  1.

Function
REQ-012 Constants: arid 0; arsize $clog2(`MIG_BUS_W/8); arburst 01 (INCR); arlock 0; arcache 2; arprot 010; arqos 0.
REQ-013 States: R_IDLE, R_ADDR_HS, R_DATA; encoding 2 bits.
REQ-014 R_IDLE: valid=1 latches addr and len into registers, clears counter and error, goes to R_ADDR_HS next cycle; valid=0 stays.
REQ-015 araddr and arlen always drive the latched registers, never the live inputs.
REQ-016 R_ADDR_HS: arvalid=1, held until arready=1; arvalid and arready both 1 moves to R_DATA.
REQ-017 arvalid=0 in every state except R_ADDR_HS; arvalid never deasserts before handshake.
REQ-018 R_DATA: rready=1; rready=0 in R_IDLE and R_ADDR_HS.
REQ-019 Beat = rvalid and rready both 1; each beat increments a `AXI_LEN_W+1-bit counter.
REQ-020 USE_RAM=1: ready = beat, rdata = m_axi_rdata, same cycle; USE_RAM=0: both registered, one cycle later.
REQ-021 Beat with rresp != 00 sets error; error stays set until the next R_IDLE acceptance.
REQ-022 Beat with rlast=1 returns to R_IDLE; error set if counter != latched len on that beat.
REQ-023 Beat with counter == latched len and rlast=0 sets error; state stays R_DATA until rlast.
REQ-024 valid, addr and len changes outside R_IDLE are ignored; a new request needs one R_IDLE cycle after rlast.
REQ-025 len=0: single beat, rlast expected on first beat.

Reset
REQ-026 rst=1 at any time, mid-burst included: state R_IDLE, counter 0, error 0, arvalid 0, rready 0, ready 0, rdata 0, latched addr/len 0.
REQ-027 No pending beat is delivered after reset; on release the block waits in R_IDLE for valid.

Structure
REQ-028 Widths (`AXI_LEN_W, `AXI_RESP_W, `AXI_ID_W etc.) come from axi_dma.vh; `DDR_ADDR_W and `MIG_BUS_W from system.vh; state codes are local defines.
REQ-029 Single flat module, no sub-modules; pairs with axi_dma_w in a top-level axi_dma wrapper.

Verification
REQ-030 addr=0x100, len=3, arready after 2 cycles, 4 beats rresp=00, rlast on beat 4 -> araddr=0x100, arlen=3, 4 ready pulses, error=0, back to R_IDLE.
REQ-031 len=0, single beat rdata=0xA5.., rlast=1 -> one ready pulse with rdata=0xA5.., error=0.
REQ-032 len=3, rresp=10 on beat 2 -> error=1 after beat 2, still 4 pulses, error clears on next accepted valid.
REQ-033 len=3, rlast on beat 2 -> error=1, return to R_IDLE; len=1 with no rlast on beat 2 -> error=1, waits for rlast.
REQ-034 rvalid toggled randomly, addr changed mid-burst -> araddr unchanged, beat count exact; USE_RAM=0 ready lags by 1 cycle.
REQ-035 rst pulsed after beat 2 of len=7 -> all outputs 0 next edge, no further ready, new request served normally.
